pipeline_freeze_ctrl: RTL and testbench

PIPELINE_FREEZE_CTRL -- requirements
Module: pipeline_freeze_ctrl

---
 rtl/pipeline_freeze_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipeline_freeze_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_freeze_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_freeze_ctrl
// Description : Stall/flush/freeze controller for a 5-stage in-order pipeline.
//               Combines the load-use hazard, the taken-branch flush and the
//               data-memory wait into the per-stage hold/clear controls.
//               A RUN/WAIT FSM tracks multi-cycle memory waits and raises a
//               sticky timeout when a wait runs longer than WAIT_LIMIT cycles.
//
//               Optional performance counters are built only when the macro
//               FREEZE_PERF_CNT_EN is defined. Otherwise the counter ports
//               are tied to zero and no counter flops exist.
//
// Parameters  : WAIT_LIMIT    maximum legal consecutive memory-wait cycles
//               CNT_W         width of each performance counter
// Ports       : clk           pipeline clock, rising edge
//               rst           asynchronous active-high reset
//               hazard        load-use hazard (ID stage)
//               branch_taken  taken branch resolved in EXE
//               mem_req       MEM stage performs a data access this cycle
//               mem_ready     data memory completes the access this cycle
//               freeze_if     hold PC and IF/ID
//               flush_if_id   clear IF/ID
//               bubble_id_exe load a NOP into ID/EXE
//               freeze_all    hold every pipeline register
//               mem_timeout   sticky: a wait exceeded WAIT_LIMIT
//               in_wait       registered: FSM is in WAIT
//               stall_cnt     hazard-stall cycle count
//               wait_cnt      memory-wait cycle count
//               flush_cnt     flush cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_freeze_ctrl #(
  parameter int unsigned WAIT_LIMIT = 31,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_if,
  output logic             flush_if_id,
  output logic             bubble_id_exe,
  output logic             freeze_all,
  output logic             mem_timeout,
  output logic             in_wait,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] wait_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      r_state;
  logic [7:0]  r_wait_ctr;
  logic [31:0] w_wait_next;

  // A zero-wait access (req and ready together) never freezes.
  assign freeze_all = mem_req & ~mem_ready;

  // Priority: memory freeze > taken branch > load-use hazard.
  // A frozen pipeline must not flush or bubble, otherwise the held
  // instructions would be lost while memory is still busy.
  always_comb begin
    freeze_if     = 1'b0;
    flush_if_id   = 1'b0;
    bubble_id_exe = 1'b0;
    if (freeze_all) begin
      freeze_if = 1'b1;
    end else if (branch_taken) begin
      flush_if_id   = 1'b1;
      bubble_id_exe = 1'b1;
    end else if (hazard) begin
      freeze_if     = 1'b1;
      bubble_id_exe = 1'b1;
    end
  end

  // Unsaturated next wait count, widened so the limit compare cannot wrap.
  assign w_wait_next = 32'(r_wait_ctr) + 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_wait_ctr  <= 8'd0;
      mem_timeout <= 1'b0;
      in_wait     <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (freeze_all) begin
            r_state <= WAIT;
            in_wait <= 1'b1;
          end
        end
        WAIT: begin
          if (mem_ready || !mem_req) begin
            r_state <= RUN;
            in_wait <= 1'b0;
          end
        end
        default: begin
          r_state <= RUN;
          in_wait <= 1'b0;
        end
      endcase

      if (freeze_all) begin
        if (r_wait_ctr != 8'hFF) begin
          r_wait_ctr <= r_wait_ctr + 8'd1;
        end
        if (w_wait_next > WAIT_LIMIT) begin
          mem_timeout <= 1'b1;
        end
      end else if (r_state == WAIT) begin
        // Leaving WAIT: the next wait starts counting from zero.
        r_wait_ctr <= 8'd0;
      end
    end
  end

`ifdef FREEZE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall_inc;

  // A hazard stall is a front-end hold that is not caused by memory.
  assign w_stall_inc = freeze_if & ~freeze_all;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_wait_cnt  <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (freeze_all && (r_wait_cnt != '1)) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
      if (flush_if_id && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign wait_cnt  = r_wait_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign wait_cnt  = '0;
  assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_freeze_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_freeze_ctrl
// Description : Directed self-checking bench for pipeline_freeze_ctrl.
//               Two instances share one stimulus: dut uses default
//               parameters, dut3 uses WAIT_LIMIT=3 and CNT_W=4 to reach the
//               timeout and counter-saturation boundaries quickly.
//               Expected counter values follow FREEZE_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_freeze_ctrl;

`ifdef FREEZE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic hazard, branch_taken, mem_req, mem_ready;

  logic        freeze_if, flush_if_id, bubble_id_exe, freeze_all, mem_timeout, in_wait;
  logic [31:0] stall_cnt, wait_cnt, flush_cnt;
  logic        freeze_if3, flush_if_id3, bubble_id_exe3, freeze_all3, mem_timeout3, in_wait3;
  logic [3:0]  stall_cnt3, wait_cnt3, flush_cnt3;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipeline_freeze_ctrl dut (
    .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_if(freeze_if), .flush_if_id(flush_if_id), .bubble_id_exe(bubble_id_exe),
    .freeze_all(freeze_all), .mem_timeout(mem_timeout), .in_wait(in_wait),
    .stall_cnt(stall_cnt), .wait_cnt(wait_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_freeze_ctrl #(.WAIT_LIMIT(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_if(freeze_if3), .flush_if_id(flush_if_id3), .bubble_id_exe(bubble_id_exe3),
    .freeze_all(freeze_all3), .mem_timeout(mem_timeout3), .in_wait(in_wait3),
    .stall_cnt(stall_cnt3), .wait_cnt(wait_cnt3), .flush_cnt(flush_cnt3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic fi, input logic fl, input logic bb,
                         input logic fa);
    chk({tag, ".freeze_if"},     32'(freeze_if),     32'(fi));
    chk({tag, ".flush_if_id"},   32'(flush_if_id),   32'(fl));
    chk({tag, ".bubble_id_exe"}, 32'(bubble_id_exe), 32'(bb));
    chk({tag, ".freeze_all"},    32'(freeze_all),    32'(fa));
    chk({tag, ".freeze_all3"},   32'(freeze_all3),   32'(fa));
  endtask

  initial begin
    rst = 1'b1; hazard = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    #12;
    // Reset state
    chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.in_wait",     32'(in_wait),     32'd0);
    chk("reset.mem_timeout", 32'(mem_timeout), 32'd0);
    chk("reset.stall_cnt",   stall_cnt,        32'd0);
    chk("reset.wait_cnt",    wait_cnt,         32'd0);
    chk("reset.flush_cnt",   flush_cnt,        32'd0);
    rst = 1'b0;
    tick();

    // Hazard only, one cycle
    hazard = 1'b1; #1;
    chk_ctl("hazard", 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    hazard = 1'b0; #1;
    chk("hazard.stall_cnt",  stall_cnt,         PERF ? 32'd1 : 32'd0);
    chk("hazard.stall_cnt3", 32'(stall_cnt3),   PERF ? 32'd1 : 32'd0);
    chk("hazard.in_wait",    32'(in_wait),      32'd0);

    // Branch wins over hazard
    branch_taken = 1'b1; hazard = 1'b1; #1;
    chk_ctl("br_hz", 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    branch_taken = 1'b0; hazard = 1'b0; #1;
    chk("br_hz.flush_cnt", flush_cnt, PERF ? 32'd1 : 32'd0);
    chk("br_hz.stall_cnt", stall_cnt, PERF ? 32'd1 : 32'd0);

    // Zero-wait access
    mem_req = 1'b1; mem_ready = 1'b1; #1;
    chk_ctl("zero_wait", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("zero_wait.in_wait",  32'(in_wait), 32'd0);
    chk("zero_wait.wait_cnt", wait_cnt,     32'd0);

    // Five-cycle memory wait with a taken branch held throughout
    mem_req = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk_ctl($sformatf("wait_c%0d", c), 1'b1, 1'b0, 1'b0, 1'b1);
      chk($sformatf("wait_c%0d.in_wait", c),      32'(in_wait),      32'(c >= 2));
      chk($sformatf("wait_c%0d.mem_timeout3", c), 32'(mem_timeout3), 32'(c >= 5));
      chk($sformatf("wait_c%0d.mem_timeout", c),  32'(mem_timeout),  32'd0);
      tick();
    end
    mem_ready = 1'b1; #1;
    chk_ctl("wait_c6", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("wait_c6.in_wait", 32'(in_wait), 32'd1);
    tick();
    mem_req = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0; #1;
    chk("wait_end.in_wait",      32'(in_wait),      32'd0);
    chk("wait_end.wait_cnt",     wait_cnt,          PERF ? 32'd5 : 32'd0);
    chk("wait_end.wait_cnt3",    32'(wait_cnt3),    PERF ? 32'd5 : 32'd0);
    chk("wait_end.flush_cnt",    flush_cnt,         PERF ? 32'd2 : 32'd0);
    chk("wait_end.stall_cnt",    stall_cnt,         PERF ? 32'd1 : 32'd0);
    chk("wait_end.mem_timeout3", 32'(mem_timeout3), 32'd1);
    chk("wait_end.mem_timeout",  32'(mem_timeout),  32'd0);

    // Reset in the middle of a wait
    mem_req = 1'b1; mem_ready = 1'b0; #1;
    tick();
    chk("rst_mid.in_wait_before", 32'(in_wait), 32'd1);
    rst = 1'b1; #1;
    chk("rst_mid.in_wait",      32'(in_wait),      32'd0);
    chk("rst_mid.in_wait3",     32'(in_wait3),     32'd0);
    chk("rst_mid.mem_timeout3", 32'(mem_timeout3), 32'd0);
    chk("rst_mid.stall_cnt",    stall_cnt,         32'd0);
    chk("rst_mid.wait_cnt",     wait_cnt,          32'd0);
    chk("rst_mid.flush_cnt3",   32'(flush_cnt3),   32'd0);
    chk("rst_mid.freeze_all",   32'(freeze_all),   32'd1);
    mem_ready = 1'b1; #1;
    chk("rst_mid.freeze_all_rdy", 32'(freeze_all), 32'd0);
    mem_req = 1'b0; mem_ready = 1'b0; #1;
    rst = 1'b0;
    tick();
    chk("rst_mid.in_wait_after", 32'(in_wait), 32'd0);

    // Three-cycle waits stay within WAIT_LIMIT=3; the counter must restart
    mem_req = 1'b1; mem_ready = 1'b0;
    repeat (3) tick();
    chk("lim_a.in_wait",      32'(in_wait3),     32'd1);
    chk("lim_a.mem_timeout3", 32'(mem_timeout3), 32'd0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    repeat (3) tick();
    chk("lim_b.mem_timeout3", 32'(mem_timeout3), 32'd0);
    tick();
    chk("lim_c.mem_timeout3", 32'(mem_timeout3), 32'd1);
    mem_req = 1'b0;
    tick();
    chk("lim_c.in_wait",   32'(in_wait),   32'd0);
    chk("lim_c.wait_cnt",  wait_cnt,       PERF ? 32'd7 : 32'd0);
    chk("lim_c.wait_cnt3", 32'(wait_cnt3), PERF ? 32'd7 : 32'd0);

    // Counter saturation: 20 hazard cycles
    hazard = 1'b1;
    repeat (20) tick();
    hazard = 1'b0; #1;
    chk("sat.stall_cnt",  stall_cnt,        PERF ? 32'd20 : 32'd0);
    chk("sat.stall_cnt3", 32'(stall_cnt3),  PERF ? 32'd15 : 32'd0);

    // Memory freeze overrides branch and hazard
    hazard = 1'b1; branch_taken = 1'b1; mem_req = 1'b1; mem_ready = 1'b0; #1;
    chk_ctl("prio", 1'b1, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
